sha256_autopad_hasher: RTL

Memory-mapped SHA-2 hasher for word-aligned messages of run-time length (0 to 2^LEN_W-1 words). It generates SHA padding and the length field in hardware, derives the block count itself, and processes any number of 512-bit blocks at one round per clock. The digest is written back to the shared word memory. It is the generalised successor to the fixed two-block hasher: run-time length, SHA-224/256 mode, explicit busy/done handshake, and a synchronous start-accept rule.

---
 rtl/sha256_autopad_hasher.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_autopad_hasher.sv
// SHA-224/256 hasher over a word-aligned message held in shared word memory.
// Padding and the bit-length field are generated in hardware; one round per
// clock, 67 cycles per 512-bit block; digest written back word by word.
module sha256_autopad_hasher #(
  parameter int MODE_224 = 0,
  parameter int LEN_W    = 12,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  msg_words,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  // Stream indices run to 16*B-1 <= N+18, so two spare bits cover them.
  localparam int JW   = LEN_W + 2;
  localparam int NOUT = (MODE_224 != 0) ? 7 : 8;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_PREF, S_ROUNDS, S_POST, S_WRITE, S_DONE
  } state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] iv(input int unsigned i);
    logic [31:0] v;
    if (MODE_224 != 0) begin
      case (i)
        0: v = 32'hc1059ed8;  1: v = 32'h367cd507;
        2: v = 32'h3070dd17;  3: v = 32'hf70e5939;
        4: v = 32'hffc00b31;  5: v = 32'h68581511;
        6: v = 32'h64f98fa7;  default: v = 32'hbefa4fa4;
      endcase
    end else begin
      case (i)
        0: v = 32'h6a09e667;  1: v = 32'hbb67ae85;
        2: v = 32'h3c6ef372;  3: v = 32'ha54ff53a;
        4: v = 32'h510e527f;  5: v = 32'h9b05688c;
        6: v = 32'h1f83d9ab;  default: v = 32'h5be0cd19;
      endcase
    end
    return v;
  endfunction

  state_t            r_state;
  logic [JW-1:0]     r_n;
  logic [JW-1:0]     r_nblk;
  logic [JW-1:0]     r_blk;
  logic [ADDR_W-1:0] r_msg_addr;
  logic [ADDR_W-1:0] r_out_addr;
  logic [5:0]        r_t;
  logic [3:0]        r_widx;
  logic [31:0]       r_hs [8];
  logic [31:0]       r_va, r_vb, r_vc, r_vd, r_ve, r_vf, r_vg, r_vh;
  logic [31:0]       r_w [16];
  logic              r_busy;
  logic              r_done;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic [JW-1:0]     w_base;
  logic [JW-1:0]     w_last;
  logic              w_fvalid;
  logic [4:0]        w_foff;
  logic [JW-1:0]     w_fj;
  logic              w_fetch;
  logic [JW-1:0]     w_sj;
  logic [31:0]       w_stream;
  logic [31:0]       w_wt;
  logic [31:0]       w_t1;
  logic [31:0]       w_t2;

  assign mem_clk        = clk;
  assign busy           = r_busy;
  assign done           = r_done;
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_write_data = r_wdata;

  // Fetch runs two words ahead of consumption (INIT -> word 0, PREF -> word 1,
  // round t -> word t+2); the padded word for the current round is chosen here.
  always_comb begin
    w_base   = r_blk << 4;
    w_last   = (r_nblk << 4) - JW'(1);
    w_fvalid = 1'b0;
    w_foff   = '0;
    case (r_state)
      S_INIT:   w_fvalid = 1'b1;
      S_PREF: begin
        w_fvalid = 1'b1;
        w_foff   = 5'd1;
      end
      S_ROUNDS: begin
        w_fvalid = (r_t < 6'd14);
        w_foff   = r_t[4:0] + 5'd2;
      end
      default: ;
    endcase
    w_fj    = w_base + JW'(w_foff);
    w_fetch = w_fvalid && (w_fj < r_n);
    w_sj    = w_base + JW'(r_t[3:0]);
    if (w_sj < r_n)
      w_stream = mem_read_data;
    else if (w_sj == r_n)
      w_stream = 32'h8000_0000;
    else if (w_sj == w_last)
      w_stream = 32'(r_n) << 5;
    else
      w_stream = '0;
    w_wt = (r_t < 6'd16) ? w_stream
                         : ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];
    w_t1 = r_vh + bsig1(r_ve) + ((r_ve & r_vf) ^ (~r_ve & r_vg)) + K_TAB[r_t] + w_wt;
    w_t2 = bsig0(r_va) + ((r_va & r_vb) ^ (r_va & r_vc) ^ (r_vb & r_vc));
  end

  // Control FSM, compression datapath and registered memory/handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_nblk     <= '0;
      r_blk      <= '0;
      r_msg_addr <= '0;
      r_out_addr <= '0;
      r_t        <= '0;
      r_widx     <= '0;
      for (int unsigned i = 0; i < 8; i++) r_hs[i] <= '0;
      for (int unsigned i = 0; i < 16; i++) r_w[i] <= '0;
      r_va <= '0; r_vb <= '0; r_vc <= '0; r_vd <= '0;
      r_ve <= '0; r_vf <= '0; r_vg <= '0; r_vh <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      // Reads stop at the last message word; the address simply holds after.
      if (w_fetch) r_addr <= r_msg_addr + ADDR_W'(w_fj);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n        <= JW'(msg_words);
            r_nblk     <= (JW'(msg_words) + JW'(18)) >> 4;
            r_msg_addr <= message_addr;
            r_out_addr <= output_addr;
            r_blk      <= '0;
            for (int unsigned i = 0; i < 8; i++) r_hs[i] <= iv(i);
            r_busy     <= 1'b1;
            r_state    <= S_INIT;
          end
        end
        S_INIT: begin
          r_va <= r_hs[0]; r_vb <= r_hs[1]; r_vc <= r_hs[2]; r_vd <= r_hs[3];
          r_ve <= r_hs[4]; r_vf <= r_hs[5]; r_vg <= r_hs[6]; r_vh <= r_hs[7];
          r_t     <= '0;
          r_state <= S_PREF;
        end
        S_PREF: r_state <= S_ROUNDS;
        S_ROUNDS: begin
          r_vh <= r_vg;
          r_vg <= r_vf;
          r_vf <= r_ve;
          r_ve <= r_vd + w_t1;
          r_vd <= r_vc;
          r_vc <= r_vb;
          r_vb <= r_va;
          r_va <= w_t1 + w_t2;
          for (int unsigned i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
          r_w[15] <= w_wt;
          r_t     <= r_t + 6'd1;
          if (r_t == 6'd63) r_state <= S_POST;
        end
        S_POST: begin
          r_hs[0] <= r_hs[0] + r_va;
          r_hs[1] <= r_hs[1] + r_vb;
          r_hs[2] <= r_hs[2] + r_vc;
          r_hs[3] <= r_hs[3] + r_vd;
          r_hs[4] <= r_hs[4] + r_ve;
          r_hs[5] <= r_hs[5] + r_vf;
          r_hs[6] <= r_hs[6] + r_vg;
          r_hs[7] <= r_hs[7] + r_vh;
          r_blk   <= r_blk + JW'(1);
          if (r_blk + JW'(1) == r_nblk) begin
            // First digest word is the just-summed H[0], issued on the POST edge.
            r_we    <= 1'b1;
            r_addr  <= r_out_addr;
            r_wdata <= r_hs[0] + r_va;
            r_widx  <= 4'd1;
            r_state <= S_WRITE;
          end else begin
            r_state <= S_INIT;
          end
        end
        S_WRITE: begin
          if (r_widx == 4'(NOUT)) begin
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_out_addr + ADDR_W'(r_widx);
            r_wdata <= r_hs[r_widx[2:0]];
            r_widx  <= r_widx + 4'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
